// File: rtl/video_palette.sv
// Indexed-colour lookup: 256 x 24-bit CLUT programmed over the mem_clk register
// port, read per pixel in the pxl_clk_i domain through the second RAM port.
module video_palette #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned ENTRIES    = 256
) (
  input  logic                  mem_clk,
  input  logic                  rst_ni,
  input  logic                  pxl_clk_i,
  input  logic                  pxl_clk_en_i,
  input  logic                  mem_en,
  input  logic [3:0]            mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_write,
  output logic [31:0]           mem_read,
  input  logic [7:0]            idx_i,
  input  logic                  idx_valid_i,
  output logic [23:0]           rgb_o,
  output logic                  rgb_valid_o
);

  localparam int unsigned AW = ADDR_WIDTH - 2;
  localparam logic [AW-1:0] OFF_WIDX   = AW'(0);
  localparam logic [AW-1:0] OFF_DATA   = AW'(1);
  localparam logic [AW-1:0] OFF_RIDX   = AW'(2);
  localparam logic [AW-1:0] OFF_DATA8  = AW'(3);
  localparam logic [AW-1:0] OFF_STATUS = AW'(4);

  typedef enum logic [1:0] {
    SEQ_R = 2'd0,
    SEQ_G = 2'd1,
    SEQ_B = 2'd2
  } seq_e;

  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_RD   = 2'd1,
    PF_CAP  = 2'd2
  } pf_e;

  logic [23:0] clut [ENTRIES];

  logic [AW-1:0] word;
  logic          wr, rd;
  logic          wr_widx, wr_data, wr_ridx, wr_data8, rd_data;
  logic [7:0]    widx_q, ridx_q;
  logic [7:0]    stage_r_q, stage_g_q;
  logic [23:0]   pf_rdata;
  logic [23:0]   prefetch_q;
  seq_e          seq_q, seq_next;
  pf_e           pf_q, pf_next;
  logic          busy;
  logic          ridx_chg;
  logic          clut_we;
  logic [23:0]   clut_wdata;
  logic [31:0]   rdata_mux;
  logic [23:0]   pxl_q;
  logic          vld_q;
  logic          unused;

  assign unused = ^{mem_write[31:24], mem_addr[1:0]};

  // Partial byte-enable patterns are neither a write nor a read.
  assign word     = mem_addr[ADDR_WIDTH-1:2];
  assign wr       = mem_en & (&mem_we);
  assign rd       = mem_en & ~(|mem_we);
  assign wr_widx  = wr & (word == OFF_WIDX);
  assign wr_data  = wr & (word == OFF_DATA);
  assign wr_ridx  = wr & (word == OFF_RIDX);
  assign wr_data8 = wr & (word == OFF_DATA8);
  assign rd_data  = rd & (word == OFF_DATA);

  // Byte-sequence FSM
  always_ff @(posedge mem_clk or negedge rst_ni) begin
    if (!rst_ni) seq_q <= SEQ_R;
    else         seq_q <= seq_next;
  end

  always_comb begin
    seq_next = seq_q;
    if (wr_widx) begin
      seq_next = SEQ_R;
    end else if (wr_data8) begin
      case (seq_q)
        SEQ_R:   seq_next = SEQ_G;
        SEQ_G:   seq_next = SEQ_B;
        default: seq_next = SEQ_R;
      endcase
    end
  end

  always_comb begin
    clut_we    = wr_data | (wr_data8 & (seq_q == SEQ_B));
    clut_wdata = {stage_r_q, stage_g_q, mem_write[7:0]};
    if (wr_data) clut_wdata = mem_write[23:0];
  end

  always_ff @(posedge mem_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      widx_q    <= '0;
      stage_r_q <= '0;
      stage_g_q <= '0;
    end else begin
      if (wr_widx)      widx_q <= mem_write[7:0];
      else if (clut_we) widx_q <= widx_q + 8'd1;

      if (wr_widx) begin
        stage_r_q <= '0;
        stage_g_q <= '0;
      end else if (wr_data8 && seq_q == SEQ_R) begin
        stage_r_q <= mem_write[7:0];
      end else if (wr_data8 && seq_q == SEQ_G) begin
        stage_g_q <= mem_write[7:0];
      end
    end
  end

  always_ff @(posedge mem_clk) begin
    if (clut_we) clut[widx_q] <= clut_wdata;
  end

  // Read prefetch FSM; a new RIDX always restarts the fetch.
  assign ridx_chg = wr_ridx | rd_data;
  assign busy     = (pf_q != PF_IDLE);

  always_ff @(posedge mem_clk or negedge rst_ni) begin
    if (!rst_ni) pf_q <= PF_IDLE;
    else         pf_q <= pf_next;
  end

  always_comb begin
    pf_next = pf_q;
    if (ridx_chg) begin
      pf_next = PF_RD;
    end else begin
      case (pf_q)
        PF_RD:   pf_next = PF_CAP;
        PF_CAP:  pf_next = PF_IDLE;
        default: pf_next = PF_IDLE;
      endcase
    end
  end

  always_ff @(posedge mem_clk) begin
    if (pf_q == PF_RD) pf_rdata <= clut[ridx_q];
  end

  always_ff @(posedge mem_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ridx_q     <= '0;
      prefetch_q <= '0;
    end else begin
      if (wr_ridx)      ridx_q <= mem_write[7:0];
      else if (rd_data) ridx_q <= ridx_q + 8'd1;

      if (pf_q == PF_CAP) prefetch_q <= pf_rdata;
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (word)
      OFF_WIDX:   rdata_mux = {24'd0, widx_q};
      OFF_DATA:   rdata_mux = {8'd0, prefetch_q};
      OFF_RIDX:   rdata_mux = {24'd0, ridx_q};
      OFF_STATUS: rdata_mux = {29'd0, seq_q, busy};
      default:    rdata_mux = '0;
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_ni) begin
    if (!rst_ni)     mem_read <= '0;
    else if (mem_en) mem_read <= rdata_mux;
  end

  // Pixel side: RAM output register has no reset; the cleared valid masks it.
  always_ff @(posedge pxl_clk_i) begin
    if (pxl_clk_en_i) pxl_q <= clut[idx_i];
  end

  always_ff @(posedge pxl_clk_i or negedge rst_ni) begin
    if (!rst_ni)           vld_q <= 1'b0;
    else if (pxl_clk_en_i) vld_q <= idx_valid_i;
  end

  assign rgb_o       = vld_q ? pxl_q : '0;
  assign rgb_valid_o = vld_q;

endmodule

// File: tb/tb_video_palette.sv
// Directed bench for video_palette: register port, CLUT load paths, prefetch
// timing, pixel lookup and reset behaviour against hand-computed values.
module tb_video_palette;

  logic        mem_clk = 1'b0;
  logic        pxl_clk_i = 1'b0;
  logic        rst_ni;
  logic        pxl_clk_en_i;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_write;
  logic [31:0] mem_read;
  logic [7:0]  idx_i;
  logic        idx_valid_i;
  logic [23:0] rgb_o;
  logic        rgb_valid_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  localparam logic [9:0] W_WIDX   = 10'd0;
  localparam logic [9:0] W_DATA   = 10'd1;
  localparam logic [9:0] W_RIDX   = 10'd2;
  localparam logic [9:0] W_DATA8  = 10'd3;
  localparam logic [9:0] W_STATUS = 10'd4;
  localparam logic [9:0] W_NONE   = 10'd5;

  always #5 mem_clk = ~mem_clk;
  always #7 pxl_clk_i = ~pxl_clk_i;

  video_palette #(.ADDR_WIDTH(12), .ENTRIES(256)) dut (
    .mem_clk      (mem_clk),
    .rst_ni       (rst_ni),
    .pxl_clk_i    (pxl_clk_i),
    .pxl_clk_en_i (pxl_clk_en_i),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .idx_i        (idx_i),
    .idx_valid_i  (idx_valid_i),
    .rgb_o        (rgb_o),
    .rgb_valid_o  (rgb_valid_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_acc(input logic [9:0] word, input logic [3:0] we,
                         input logic [31:0] wdata, output logic [31:0] rdata);
    @(posedge mem_clk); #1;
    mem_en = 1'b1; mem_we = we; mem_addr = {word, 2'b00}; mem_write = wdata;
    @(posedge mem_clk); #1;
    rdata = mem_read;
    mem_en = 1'b0; mem_we = 4'h0;
    repeat (2) @(posedge mem_clk);
  endtask

  task automatic wr(input logic [9:0] word, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus_acc(word, 4'hF, wdata, dummy);
  endtask

  task automatic rd(input logic [9:0] word, output logic [31:0] rdata);
    bus_acc(word, 4'h0, 32'h0, rdata);
  endtask

  // One access, then STATUS read on each of the next three cycles.
  task automatic probe(input logic [9:0] word, input logic [3:0] we, input logic [31:0] wdata,
                       output logic [31:0] first, output logic [31:0] s1,
                       output logic [31:0] s2, output logic [31:0] s3);
    @(posedge mem_clk); #1;
    mem_en = 1'b1; mem_we = we; mem_addr = {word, 2'b00}; mem_write = wdata;
    @(posedge mem_clk); #1;
    first = mem_read;
    mem_we = 4'h0; mem_addr = {W_STATUS, 2'b00};
    @(posedge mem_clk); #1; s1 = mem_read;
    @(posedge mem_clk); #1; s2 = mem_read;
    @(posedge mem_clk); #1; s3 = mem_read;
    mem_en = 1'b0;
    repeat (2) @(posedge mem_clk);
  endtask

  task automatic pix_step(input logic [7:0] idx, input logic vld);
    idx_i = idx; idx_valid_i = vld;
    @(posedge pxl_clk_i); #1;
  endtask

  initial begin
    logic [31:0] r, f, s1, s2, s3;
    rst_ni = 1'b0; pxl_clk_en_i = 1'b1; mem_en = 1'b0; mem_we = 4'h0;
    mem_addr = '0; mem_write = '0; idx_i = '0; idx_valid_i = 1'b0;
    #1;
    check("rst_rgb", {8'd0, rgb_o}, 32'h0);
    check("rst_rgb_valid", {31'd0, rgb_valid_o}, 32'h0);
    check("rst_mem_read", mem_read, 32'h0);
    repeat (3) @(posedge mem_clk);
    #2 rst_ni = 1'b1;

    rd(W_WIDX, r);   check("rst_widx", r, 32'h0);
    rd(W_DATA, r);   check("rst_data", r, 32'h0);
    rd(W_RIDX, r);   check("rst_ridx", r, 32'h1);   // DATA read bumped RIDX
    rd(W_DATA8, r);  check("rst_data8", r, 32'h0);
    rd(W_STATUS, r); check("rst_status", r, 32'h0);

    // 24-bit writes wrapping WIDX
    wr(W_WIDX, 32'hFE);
    wr(W_DATA, 32'hFF112233);
    wr(W_DATA, 32'h00445566);
    wr(W_DATA, 32'h00778899);
    rd(W_WIDX, r); check("widx_wrap", r, 32'h01);
    wr(W_RIDX, 32'hFE);
    rd(W_DATA, r); check("clut_fe", r, 32'h112233);
    rd(W_DATA, r); check("clut_ff", r, 32'h445566);
    rd(W_DATA, r); check("clut_00", r, 32'h778899);
    rd(W_RIDX, r); check("ridx_wrap", r, 32'h01);

    // Byte-sequential write
    wr(W_WIDX, 32'h10);
    wr(W_DATA8, 32'hAA); rd(W_STATUS, r); check("seq_g", r, 32'h2);
    wr(W_DATA8, 32'hBB); rd(W_STATUS, r); check("seq_b", r, 32'h4);
    wr(W_DATA8, 32'hCC); rd(W_STATUS, r); check("seq_r", r, 32'h0);
    rd(W_WIDX, r); check("seq_widx", r, 32'h11);
    bus_acc(W_WIDX, 4'h3, 32'h55, r);
    rd(W_WIDX, r); check("partial_we_ignored", r, 32'h11);

    // Aborted sequence
    wr(W_WIDX, 32'h10);
    wr(W_DATA8, 32'h01);
    wr(W_DATA8, 32'h02); rd(W_STATUS, r); check("abort_pre", r, 32'h4);
    wr(W_WIDX, 32'h10);  rd(W_STATUS, r); check("abort_status", r, 32'h0);

    // Readback with busy timing
    probe(W_RIDX, 4'hF, 32'h10, f, s1, s2, s3);
    check("ridx_busy1", s1, 32'h1);
    check("ridx_busy2", s2, 32'h1);
    check("ridx_busy3", s3, 32'h0);
    probe(W_DATA, 4'h0, 32'h0, f, s1, s2, s3);
    check("clut_10", f, 32'hAABBCC);
    check("inc_busy1", s1, 32'h1);
    check("inc_busy2", s2, 32'h1);
    check("inc_busy3", s3, 32'h0);
    rd(W_RIDX, r); check("ridx_inc", r, 32'h11);

    // 24-bit write mid-sequence leaves the FSM alone
    wr(W_WIDX, 32'h20);
    wr(W_DATA8, 32'h01);
    wr(W_DATA, 32'h123456);
    rd(W_STATUS, r); check("mid_seq_status", r, 32'h2);
    wr(W_DATA8, 32'h02);
    wr(W_DATA8, 32'h03);
    rd(W_WIDX, r); check("mid_seq_widx", r, 32'h22);
    wr(W_RIDX, 32'h20);
    rd(W_DATA, r); check("clut_20", r, 32'h123456);
    rd(W_DATA, r); check("clut_21", r, 32'h010203);
    wr(W_NONE, 32'hDEADBEEF);
    rd(W_NONE, r); check("unmapped", r, 32'h0);

    // Pixel lookup
    @(posedge pxl_clk_i); #1;
    pix_step(8'h10, 1'b1);
    check("pix_10", {8'd0, rgb_o}, 32'hAABBCC);
    check("pix_10_valid", {31'd0, rgb_valid_o}, 32'h1);
    pix_step(8'h21, 1'b1);
    check("pix_21", {8'd0, rgb_o}, 32'h010203);
    pix_step(8'h21, 1'b0);
    check("pix_invalid", {8'd0, rgb_o}, 32'h0);
    check("pix_invalid_valid", {31'd0, rgb_valid_o}, 32'h0);
    pix_step(8'hFE, 1'b1);
    check("pix_fe", {8'd0, rgb_o}, 32'h112233);
    pxl_clk_en_i = 1'b0;
    pix_step(8'h10, 1'b0);
    pix_step(8'h10, 1'b0);
    pix_step(8'h10, 1'b0);
    check("freeze_rgb", {8'd0, rgb_o}, 32'h112233);
    check("freeze_valid", {31'd0, rgb_valid_o}, 32'h1);
    pxl_clk_en_i = 1'b1;
    pix_step(8'h10, 1'b0);
    check("unfreeze_rgb", {8'd0, rgb_o}, 32'h0);
    pix_step(8'h10, 1'b1);
    check("pre_reset_valid", {31'd0, rgb_valid_o}, 32'h1);

    // Reset mid byte-sequence
    wr(W_WIDX, 32'h30);
    wr(W_DATA8, 32'h55);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rgb_valid_o}, 32'h0);
    check("mid_rst_rgb", {8'd0, rgb_o}, 32'h0);
    idx_valid_i = 1'b0;
    @(posedge mem_clk); #2 rst_ni = 1'b1;
    rd(W_STATUS, r); check("post_rst_status", r, 32'h0);
    rd(W_WIDX, r);   check("post_rst_widx", r, 32'h0);
    wr(W_DATA8, 32'h66); rd(W_STATUS, r); check("post_rst_seq_g", r, 32'h2);
    wr(W_DATA8, 32'h77);
    wr(W_DATA8, 32'h88);
    rd(W_WIDX, r); check("post_rst_widx_inc", r, 32'h01);
    wr(W_RIDX, 32'h00);
    rd(W_DATA, r); check("post_rst_clut_00", r, 32'h667788);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
